// File: rtl/vga_pkg.sv
// +----------------------------------------------------------------------+
// | vga_pkg: timing record, standard mode constants and length helper.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package vga_pkg;

    localparam int VGA_CW = 12;

    typedef struct packed {
        logic [VGA_CW-1:0] h_active;
        logic [VGA_CW-1:0] h_fp;
        logic [VGA_CW-1:0] h_sync;
        logic [VGA_CW-1:0] h_bp;
        logic [VGA_CW-1:0] v_active;
        logic [VGA_CW-1:0] v_fp;
        logic [VGA_CW-1:0] v_sync;
        logic [VGA_CW-1:0] v_bp;
    } timing_t;

    localparam timing_t TIMING_640x480 = '{
        h_active: 12'd640, h_fp: 12'd16, h_sync: 12'd96,  h_bp: 12'd48,
        v_active: 12'd480, v_fp: 12'd10, v_sync: 12'd2,   v_bp: 12'd33
    };

    localparam timing_t TIMING_800x600 = '{
        h_active: 12'd800, h_fp: 12'd40, h_sync: 12'd128, h_bp: 12'd88,
        v_active: 12'd600, v_fp: 12'd1,  v_sync: 12'd4,   v_bp: 12'd23
    };

    // Full-width sum so callers can detect a total that no longer fits the counters.
    function automatic int unsigned total_len(
        input logic [VGA_CW-1:0] active,
        input logic [VGA_CW-1:0] fp,
        input logic [VGA_CW-1:0] sync,
        input logic [VGA_CW-1:0] bp
    );
        return 32'(active) + 32'(fp) + 32'(sync) + 32'(bp);
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
// +----------------------------------------------------------------------+
// | vga_timing_gen_if: timing-configuration handshake (valid/ready/err). |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface vga_timing_gen_if;
    import vga_pkg::*;

    logic    i_cfg_valid;
    logic    o_cfg_ready;
    timing_t i_cfg_timing;
    logic    o_cfg_err;

    modport master (
        output i_cfg_valid,
        output i_cfg_timing,
        input  o_cfg_ready,
        input  o_cfg_err
    );

    modport slave (
        input  i_cfg_valid,
        input  i_cfg_timing,
        output o_cfg_ready,
        output o_cfg_err
    );

endinterface

`default_nettype wire

// File: rtl/vga_axis_counter.sv
// +----------------------------------------------------------------------+
// | vga_axis_counter: one-axis position counter with wrap and region     |
// | decode of the next position.                     Rev 1.0             |
// +----------------------------------------------------------------------+
`default_nettype none

module vga_axis_counter #(
    parameter int CW = 12
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          run,
    input  wire logic          step,
    input  wire logic [CW-1:0] len_active,
    input  wire logic [CW-1:0] len_fp,
    input  wire logic [CW-1:0] len_sync,
    input  wire logic [CW-1:0] len_bp,
    output logic      [CW-1:0] pos,
    output logic               at_end,
    output logic               nxt_active,
    output logic               nxt_sync
);

    logic [CW+1:0] w_sync_start;
    logic [CW+1:0] w_sync_end;
    logic [CW+1:0] w_last;
    logic [CW+1:0] w_nxt_ext;
    logic [CW-1:0] w_nxt;
    logic [CW-1:0] r_pos;

    assign w_sync_start = {2'b00, len_active} + {2'b00, len_fp};
    assign w_sync_end   = w_sync_start + {2'b00, len_sync};
    assign w_last       = w_sync_end + {2'b00, len_bp} - (CW+2)'(1);
    assign at_end       = ({2'b00, r_pos} == w_last);

    // Held at 0 until the first edge after reset so that edge presents position 0.
    always_comb begin
        w_nxt = r_pos;
        if (!run) begin
            w_nxt = '0;
        end else if (step) begin
            w_nxt = at_end ? '0 : r_pos + CW'(1);
        end
    end

    assign w_nxt_ext  = {2'b00, w_nxt};
    assign nxt_active = (w_nxt_ext < {2'b00, len_active});
    assign nxt_sync   = (w_nxt_ext >= w_sync_start) && (w_nxt_ext < w_sync_end);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos <= '0;
        end else begin
            r_pos <= w_nxt;
        end
    end

    assign pos = r_pos;

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// +----------------------------------------------------------------------+
// | vga_timing_gen: VGA raster timing with runtime timing handshake.     |
// | VGA_TIMING_STROBES_EN adds o_line_start / o_frame_start.   Rev 1.0   |
// +----------------------------------------------------------------------+
`default_nettype none

module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int      CW         = VGA_CW,
    parameter bit      H_SYNC_POL = 1'b0,
    parameter bit      V_SYNC_POL = 1'b0,
    parameter timing_t DEF_TIMING = TIMING_640x480
) (
    input  wire logic          i_VGA_CLOCK,
    input  wire logic          i_rst_n,
    vga_timing_gen_if.slave    cfg,
    output logic               o_de,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic [CW-1:0]      o_sx,
    output logic [CW-1:0]      o_sy
`ifdef VGA_TIMING_STROBES_EN
    ,
    output logic               o_line_start,
    output logic               o_frame_start
`endif
);

    timing_t r_act;
    timing_t r_pend;
    timing_t w_t;
    logic    r_run;
    logic    r_ready;
    logic    r_err;
    logic    r_pend_v;
    logic    w_h_end;
    logic    w_v_end;
    logic    w_h_nxt_act;
    logic    w_h_nxt_sync;
    logic    w_v_nxt_act;
    logic    w_v_nxt_sync;
    logic    w_frame_wrap;
    logic    w_xfer;
    logic    w_cfg_ok;

    assign w_t          = cfg.i_cfg_timing;
    assign w_xfer       = cfg.i_cfg_valid & r_ready;
    assign w_frame_wrap = r_run & w_h_end & w_v_end;

    assign w_cfg_ok = (w_t.h_active != '0) && (w_t.h_fp != '0) &&
                      (w_t.h_sync   != '0) && (w_t.h_bp != '0) &&
                      (w_t.v_active != '0) && (w_t.v_fp != '0) &&
                      (w_t.v_sync   != '0) && (w_t.v_bp != '0) &&
                      (total_len(w_t.h_active, w_t.h_fp, w_t.h_sync, w_t.h_bp) < (32'd1 << CW)) &&
                      (total_len(w_t.v_active, w_t.v_fp, w_t.v_sync, w_t.v_bp) < (32'd1 << CW));

    vga_axis_counter #(.CW(CW)) u_h_axis (
        .clk        (i_VGA_CLOCK),
        .rst_n      (i_rst_n),
        .run        (r_run),
        .step       (1'b1),
        .len_active (r_act.h_active),
        .len_fp     (r_act.h_fp),
        .len_sync   (r_act.h_sync),
        .len_bp     (r_act.h_bp),
        .pos        (o_sx),
        .at_end     (w_h_end),
        .nxt_active (w_h_nxt_act),
        .nxt_sync   (w_h_nxt_sync)
    );

    vga_axis_counter #(.CW(CW)) u_v_axis (
        .clk        (i_VGA_CLOCK),
        .rst_n      (i_rst_n),
        .run        (r_run),
        .step       (w_h_end),
        .len_active (r_act.v_active),
        .len_fp     (r_act.v_fp),
        .len_sync   (r_act.v_sync),
        .len_bp     (r_act.v_bp),
        .pos        (o_sy),
        .at_end     (w_v_end),
        .nxt_active (w_v_nxt_act),
        .nxt_sync   (w_v_nxt_sync)
    );

    // A transfer needs ready high, so it can never coincide with applying a pending timing.
    always_ff @(posedge i_VGA_CLOCK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_run    <= 1'b0;
            r_ready  <= 1'b0;
            r_err    <= 1'b0;
            r_pend_v <= 1'b0;
            r_act    <= DEF_TIMING;
            r_pend   <= '0;
        end else begin
            r_run <= 1'b1;
            r_err <= 1'b0;
            if (w_frame_wrap && r_pend_v) begin
                r_act    <= r_pend;
                r_pend_v <= 1'b0;
            end
            if (w_xfer) begin
                r_ready <= 1'b0;
                if (w_cfg_ok) begin
                    r_pend   <= w_t;
                    r_pend_v <= 1'b1;
                end else begin
                    r_err <= 1'b1;
                end
            end else if (!r_run || r_err || (w_frame_wrap && r_pend_v)) begin
                r_ready <= 1'b1;
            end
        end
    end

    assign cfg.o_cfg_ready = r_ready;
    assign cfg.o_cfg_err   = r_err;

    always_ff @(posedge i_VGA_CLOCK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_de    <= 1'b0;
            o_hsync <= ~H_SYNC_POL;
            o_vsync <= ~V_SYNC_POL;
        end else begin
            o_de    <= w_h_nxt_act & w_v_nxt_act;
            o_hsync <= w_h_nxt_sync ? H_SYNC_POL : ~H_SYNC_POL;
            o_vsync <= w_v_nxt_sync ? V_SYNC_POL : ~V_SYNC_POL;
        end
    end

`ifdef VGA_TIMING_STROBES_EN
    always_ff @(posedge i_VGA_CLOCK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
        end else begin
            o_line_start  <= ~r_run | w_h_end;
            o_frame_start <= ~r_run | w_frame_wrap;
        end
    end
`endif

endmodule

`default_nettype wire
